// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for a 5-stage pipeline. It keeps its own shadow copy of the
// EXE/MEM/WB register tags. From that copy it drives the forwarding selects, load-use stalls,
// branch flushes and saturating event counters.
module hazard_forward_unit #(
    parameter int REG_ADDR_W   = 4,
    parameter int ZERO_REG_EN  = 0,
    parameter int MEM_LOAD_FWD = 0,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_a,
    input  logic [REG_ADDR_W-1:0] id_rs_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  flush_ifid,
    output logic                  bubble_exe,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  ld;
        logic [REG_ADDR_W-1:0] rs_a;
        logic [REG_ADDR_W-1:0] rs_b;
        logic                  use_a;
        logic                  use_b;
    } entry_t;

    localparam bit              L_ZERO      = (ZERO_REG_EN != 0);
    localparam bit              L_MEM_STALL = (MEM_LOAD_FWD == 0);
    localparam logic [CNT_W-1:0] L_CNT_MAX  = '1;

    function automatic logic f_match(input entry_t p, input logic [REG_ADDR_W-1:0] src,
                                     input logic use_src);
        return p.v & p.we & (p.rd == src) & use_src & ~(L_ZERO & (src == '0));
    endfunction

    entry_t r_ex_q;
    entry_t r_mem_q;
    entry_t r_wb_q;
    entry_t w_id_entry;

    logic [REG_ADDR_W-1:0] w_ex_src [2];
    logic [REG_ADDR_W-1:0] w_id_src [2];
    logic                  w_ex_use [2];
    logic                  w_id_use [2];
    logic                  w_ld_hit [2];
    logic [1:0]            w_fwd_sel [2];
    logic                  w_load_use;
    logic                  w_unused;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_comb begin
        w_id_entry       = '0;
        w_id_entry.v     = id_valid;
        w_id_entry.rd    = id_rd;
        w_id_entry.we    = id_we;
        w_id_entry.ld    = id_is_load;
        w_id_entry.rs_a  = id_rs_a;
        w_id_entry.rs_b  = id_rs_b;
        w_id_entry.use_a = id_use_a;
        w_id_entry.use_b = id_use_b;
    end

    assign w_ex_src[0] = r_ex_q.rs_a;
    assign w_ex_src[1] = r_ex_q.rs_b;
    assign w_ex_use[0] = r_ex_q.v & r_ex_q.use_a;
    assign w_ex_use[1] = r_ex_q.v & r_ex_q.use_b;
    assign w_id_src[0] = id_rs_a;
    assign w_id_src[1] = id_rs_b;
    assign w_id_use[0] = id_use_a;
    assign w_id_use[1] = id_use_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic w_mem_hit;
            logic w_wb_hit;
            // MEM holds the younger producer, so it takes priority over WB.
            assign w_mem_hit     = f_match(r_mem_q, w_ex_src[gi], w_ex_use[gi]);
            assign w_wb_hit      = f_match(r_wb_q, w_ex_src[gi], w_ex_use[gi]);
            assign w_fwd_sel[gi] = w_mem_hit ? 2'b01 : (w_wb_hit ? 2'b10 : 2'b00);
            assign w_ld_hit[gi]  =
                (r_ex_q.ld & f_match(r_ex_q, w_id_src[gi], w_id_use[gi])) |
                (L_MEM_STALL & r_mem_q.ld & f_match(r_mem_q, w_id_src[gi], w_id_use[gi]));
        end
    endgenerate

    assign w_load_use = id_valid & (w_ld_hit[0] | w_ld_hit[1]);
    // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
    assign stall      = w_load_use & ~branch_taken;
    assign flush_ifid = branch_taken;
    assign bubble_exe = stall | branch_taken;
    assign fwd_sel_a  = w_fwd_sel[0];
    assign fwd_sel_b  = w_fwd_sel[1];
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_q  <= '0;
            r_mem_q <= '0;
            r_wb_q  <= '0;
        end else begin
            r_wb_q  <= r_mem_q;
            r_mem_q <= r_ex_q;
            r_ex_q  <= (id_valid & ~stall & ~branch_taken) ? w_id_entry : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != L_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (branch_taken && (r_flush_cnt != L_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // WB only ever acts as a producer; its source-side tags are dead.
    assign w_unused = ^{r_wb_q.ld, r_wb_q.rs_a, r_wb_q.rs_b, r_wb_q.use_a, r_wb_q.use_b};

endmodule
